// File: rtl/xain_pkg.sv
// Shared types and constants for the Xain APF video output stage.
// Optional feature macro: XAIN_VID_SCANLINE_EN (75% dimming on odd lines).
package xain_pkg;

  typedef enum logic {
    SEEK = 1'b0,
    RUN  = 1'b1
  } vout_state_t;

  // Upper 21 bits of the APF end-of-line control word; slot goes in [2:0].
  localparam logic [20:0] APF_EOL_PREFIX = 21'd0;

`ifdef XAIN_VID_SCANLINE_EN
  // Per-channel (c>>1)+(c>>2): 75% brightness, never overflows 8 bits.
  function automatic logic [23:0] dim75(input logic [23:0] c);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*8 +: 8] = {1'b0, c[i*8+1 +: 7]} + {2'b0, c[i*8+2 +: 6]};
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/xain_vout_edge.sv
// Registered falling-edge detector qualified by the pixel enable.
// The previous level resets to 0 so a line held low through reset never
// produces a spurious fall.
module xain_vout_edge (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic d,
  output logic fall
);

  logic prev;

  // Capture the level once per pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   prev <= 1'b0;
    else if (ce) prev <= d;
  end

  assign fall = prev & ~d;

endmodule

// File: rtl/xain_apf_video_out.sv
// Xain core -> Pocket APF video bus adapter: DE-gated RGB, one-tick sync
// pulses, end-of-line control word, frame lock and active-size measurement.
// Optional feature macro: XAIN_VID_SCANLINE_EN (odd-line dimming).
module xain_apf_video_out
  import xain_pkg::*;
#(
  parameter int          HS_DELAY = 3,
  parameter logic [2:0]  EOL_SLOT = 3'd0,
  parameter int          LINE_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [23:0]       rgb_in,
  input  logic              hblank_n,
  input  logic              vblank_n,
  input  logic              hsync_n,
  input  logic              vsync_n,
  output logic [23:0]       video_rgb,
  output logic              video_de,
  output logic              video_hs,
  output logic              video_vs,
  output logic [LINE_W-1:0] active_w,
  output logic [LINE_W-1:0] active_h,
  output logic              locked
);

  localparam logic [3:0]        HS_LOAD = 4'(HS_DELAY - 1);
  localparam logic [LINE_W-1:0] CNT_MAX = '1;

  vout_state_t       state;
  logic [3:0]        hs_cnt;
  logic              hs_slip;
  logic [LINE_W-1:0] pix_cnt, line_cnt;
  logic              de_in, hs_fire, hs_want;
  logic [3:0]        lvl, fall;
  logic              hs_fall, vs_fall, hb_fall, de_fall;
  logic [23:0]       rgb_px;

  assign de_in = hblank_n & vblank_n;
  assign lvl   = {de_in, hblank_n, vsync_n, hsync_n};

  for (genvar i = 0; i < 4; i++) begin : g_edge
    xain_vout_edge u_edge (
      .clk   (clk),
      .reset (reset),
      .ce    (ce_pix),
      .d     (lvl[i]),
      .fall  (fall[i])
    );
  end

  assign hs_fall = fall[0];
  assign vs_fall = fall[1];
  assign hb_fall = fall[2];
  assign de_fall = fall[3];

  // A fresh hsync fall restarts the delay (latest wins); a delay of 1 fires at once.
  assign hs_fire = hs_fall ? (HS_DELAY == 1) : (hs_cnt == 4'd1);
  assign hs_want = hs_fire | hs_slip;

  // Pixel colour path: optional scanline dimming on odd lines.
  always_comb begin
    rgb_px = rgb_in;
`ifdef XAIN_VID_SCANLINE_EN
    if (line_cnt[0]) rgb_px = dim75(rgb_in);
`endif
  end

  // Frame-lock FSM, registered APF outputs and size measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEEK;
      locked    <= 1'b0;
      hs_cnt    <= '0;
      hs_slip   <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      active_w  <= '0;
      active_h  <= '0;
      video_rgb <= '0;
      video_de  <= 1'b0;
      video_hs  <= 1'b0;
      video_vs  <= 1'b0;
    end else if (ce_pix) begin
      if (hs_fall)            hs_cnt <= HS_LOAD;
      else if (hs_cnt != '0)  hs_cnt <= hs_cnt - 4'd1;

      case (state)
        SEEK: begin
          video_rgb <= '0;
          video_de  <= 1'b0;
          video_hs  <= 1'b0;
          video_vs  <= 1'b0;
          hs_slip   <= 1'b0;
          pix_cnt   <= '0;
          line_cnt  <= '0;
          active_w  <= '0;
          active_h  <= '0;
          // The lock tick itself carries no vs pulse.
          if (vs_fall) begin
            state  <= RUN;
            locked <= 1'b1;
          end
        end

        RUN: begin
          video_vs <= vs_fall;
          // vs has priority; a colliding hs is pushed one tick later.
          if (hs_want && vs_fall) begin
            video_hs <= 1'b0;
            hs_slip  <= 1'b1;
          end else begin
            video_hs <= hs_want;
            hs_slip  <= 1'b0;
          end

          video_de <= de_in;
          if (de_in)        video_rgb <= rgb_px;
          else if (de_fall) video_rgb <= {APF_EOL_PREFIX, EOL_SLOT};
          else              video_rgb <= '0;

          // Pixel count restarts at every line end; latched only on a DE fall.
          if (de_fall || hb_fall) begin
            pix_cnt <= '0;
            if (de_fall) active_w <= pix_cnt;
          end else if (de_in && pix_cnt != CNT_MAX) begin
            pix_cnt <= pix_cnt + 1'b1;
          end

          // Line count doubles as the lock watchdog: overflow means sync was lost.
          if (vs_fall) begin
            active_h <= line_cnt;
            line_cnt <= '0;
          end else if (de_fall) begin
            if (line_cnt == CNT_MAX) begin
              state  <= SEEK;
              locked <= 1'b0;
            end else begin
              line_cnt <= line_cnt + 1'b1;
            end
          end
        end

        default: state <= SEEK;
      endcase
    end
  end

endmodule
